game_ctrl: RTL and testbench

//   Minesweeper game controller: accepts player commands (reveal, flag, new game) and

---
 rtl/game_ctrl_if.sv | 12 +
 rtl/game_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - player command handshake between input logic and game_ctrl
interface game_ctrl_if #(
  parameter int TILE_W = 6
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [TILE_W-1:0] cmd_tile;
  logic              cmd_ready;

  modport master (output cmd_valid, cmd_op, cmd_tile, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_tile, output cmd_ready);
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - minesweeper controller: commands, flood-fill sweeps, win/lose
module game_ctrl #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int TILES = ROWS * COLS,
  localparam int TW = $clog2(TILES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TILES-1:0]   mine_map,
  input  logic [4*TILES-1:0] adj,
  input  logic               adj_done,
  game_ctrl_if.slave         cmd,
  output logic [TILES-1:0]   revealed,
  output logic [TILES-1:0]   flagged,
  output logic [1:0]         game_state,
  output logic               busy
);

  typedef enum logic [2:0] {S_WAIT_ADJ, S_PLAY, S_WIN, S_LOSE, S_SWEEP} state_t;

  localparam logic [1:0] OP_REVEAL = 2'b00;
  localparam logic [1:0] OP_FLAG   = 2'b01;
  localparam logic [1:0] OP_NEW    = 2'b10;
  localparam logic [TW-1:0] IDX_LAST = TW'(TILES - 1);

  state_t           state, state_nxt;
  logic [TILES-1:0] revealed_nxt, flagged_nxt;
  logic [TW-1:0]    idx, idx_nxt;
  logic             changed, changed_nxt;
  logic             hit;
  logic [TW-1:0]    tile;
  logic [3:0]       adj_t [TILES];
  logic [TILES-1:0] open_t, nb_any;

  assign tile = cmd.cmd_tile;

  // Bit set for every in-board 8-neighbour of (r, c); edges never wrap.
  function automatic logic [TILES-1:0] nb_mask(input int r, input int c);
    logic [TILES-1:0] m;
    m = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
            c + dc >= 0 && c + dc < COLS)
          m[(r + dr) * COLS + (c + dc)] = 1'b1;
      end
    end
    return m;
  endfunction

  for (genvar t = 0; t < TILES; t++) begin : g_tile
    assign adj_t[t]  = adj[4*t +: 4];
    assign open_t[t] = revealed[t] && (adj[4*t +: 4] == 4'd0);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam logic [TILES-1:0] NB = nb_mask(r, c);
      assign nb_any[r*COLS + c] = |(open_t & NB);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_WAIT_ADJ;
      revealed <= '0;
      flagged  <= '0;
      idx      <= '0;
      changed  <= 1'b0;
    end else begin
      state    <= state_nxt;
      revealed <= revealed_nxt;
      flagged  <= flagged_nxt;
      idx      <= idx_nxt;
      changed  <= changed_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    revealed_nxt = revealed;
    flagged_nxt  = flagged;
    idx_nxt      = idx;
    changed_nxt  = changed;
    hit          = 1'b0;
    case (state)
      S_WAIT_ADJ: if (adj_done) state_nxt = S_PLAY;
      S_PLAY: begin
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_REVEAL: begin
              if (!flagged[tile] && !revealed[tile]) begin
                revealed_nxt[tile] = 1'b1;
                if (mine_map[tile]) begin
                  state_nxt = S_LOSE;
                end else if (adj_t[tile] != 4'd0) begin
                  if (&(revealed_nxt | mine_map)) state_nxt = S_WIN;
                end else begin
                  state_nxt   = S_SWEEP;
                  idx_nxt     = '0;
                  changed_nxt = 1'b0;
                end
              end
            end
            OP_FLAG: if (!revealed[tile]) flagged_nxt[tile] = ~flagged[tile];
            OP_NEW: begin
              revealed_nxt = '0;
              flagged_nxt  = '0;
            end
            default: ;
          endcase
        end
      end
      S_SWEEP: begin
        if (!revealed[idx] && !flagged[idx] && !mine_map[idx] && nb_any[idx]) begin
          revealed_nxt[idx] = 1'b1;
          hit               = 1'b1;
        end
        if (idx == IDX_LAST) begin
          if (changed || hit) begin
            idx_nxt     = '0;
            changed_nxt = 1'b0;
          end else begin
            state_nxt = (&(revealed_nxt | mine_map)) ? S_WIN : S_PLAY;
          end
        end else begin
          idx_nxt     = idx + TW'(1);
          changed_nxt = changed | hit;
        end
      end
      S_WIN, S_LOSE: begin
        if (cmd.cmd_valid && cmd.cmd_op == OP_NEW) begin
          revealed_nxt = '0;
          flagged_nxt  = '0;
          state_nxt    = S_PLAY;
        end
      end
      default: state_nxt = S_WAIT_ADJ;
    endcase
  end

  always_comb begin
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    game_state    = 2'b00;
    case (state)
      S_PLAY:  begin cmd.cmd_ready = 1'b1; game_state = 2'b01; end
      S_SWEEP: begin busy = 1'b1; game_state = 2'b01; end
      S_WIN:   begin cmd.cmd_ready = 1'b1; game_state = 2'b10; end
      S_LOSE:  begin cmd.cmd_ready = 1'b1; game_state = 2'b11; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl
module tb_game_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  mine_map = '0;
  logic [255:0] adj = '0;
  logic         adj_done = 1'b0;
  logic [63:0]  revealed, flagged;
  logic [1:0]   game_state;
  logic         busy;
  int           errors = 0;
  int           checks = 0;

  game_ctrl_if #(.TILE_W(6)) cmd_if ();

  game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mine_map   (mine_map),
    .adj        (adj),
    .adj_done   (adj_done),
    .cmd        (cmd_if.slave),
    .revealed   (revealed),
    .flagged    (flagged),
    .game_state (game_state),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] adj_of(input logic [63:0] m);
    logic [255:0] a;
    a = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8)
              n += int'(m[(r+dr)*8 + c+dc]);
        a[4*(r*8+c) +: 4] = 4'(n);
      end
    end
    return a;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [5:0] t);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_tile  = t;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic start_board(input logic [63:0] m, input logic [255:0] a);
    @(negedge clk);
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    adj_done = 1'b0;
    mine_map = m;
    adj = a;
    @(negedge clk);
    rst = 1'b0;
    adj_done = 1'b1;
    @(negedge clk);
    adj_done = 1'b0;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = 2'b00;
    cmd_if.cmd_tile = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (revealed !== 64'h0) begin errors++; $display("FAIL reset_revealed got %h exp 0", revealed); end
    checks++; if (flagged !== 64'h0) begin errors++; $display("FAIL reset_flagged got %h exp 0", flagged); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    repeat (10) @(negedge clk);
    checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL wait_ready got %b exp 0", cmd_if.cmd_ready); end
    checks++; if (game_state !== 2'b00) begin errors++; $display("FAIL wait_state got %b exp 00", game_state); end
    adj_done = 1'b1;
    @(negedge clk);
    adj_done = 1'b0;
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL play_state got %b exp 01", game_state); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL play_ready got %b exp 1", cmd_if.cmd_ready); end
  endtask

  task automatic test_flag;
    start_board(64'h200, {64{4'd1}});
    issue(2'b01, 6'd5);
    checks++; if (flagged[5] !== 1'b1) begin errors++; $display("FAIL flag_set got %b exp 1", flagged[5]); end
    issue(2'b01, 6'd5);
    checks++; if (flagged[5] !== 1'b0) begin errors++; $display("FAIL flag_clear got %b exp 0", flagged[5]); end
    issue(2'b01, 6'd5);
    issue(2'b00, 6'd5);
    checks++; if (revealed[5] !== 1'b0) begin errors++; $display("FAIL reveal_flagged got %b exp 0", revealed[5]); end
    issue(2'b00, 6'd6);
    checks++; if (revealed !== 64'h40) begin errors++; $display("FAIL reveal_safe got %h exp 40", revealed); end
    issue(2'b01, 6'd6);
    checks++; if (flagged !== 64'h20) begin errors++; $display("FAIL flag_revealed got %h exp 20", flagged); end
    issue(2'b11, 6'd2);
    checks++; if (revealed !== 64'h40 || game_state !== 2'b01) begin errors++; $display("FAIL op11_noop got %h/%b exp 40/01", revealed, game_state); end
  endtask

  task automatic test_lose;
    issue(2'b00, 6'd9);
    checks++; if (revealed !== 64'h240) begin errors++; $display("FAIL lose_revealed got %h exp 240", revealed); end
    checks++; if (game_state !== 2'b11) begin errors++; $display("FAIL lose_state got %b exp 11", game_state); end
    issue(2'b00, 6'd0);
    checks++; if (revealed !== 64'h240) begin errors++; $display("FAIL lose_drop got %h exp 240", revealed); end
    issue(2'b10, 6'd0);
    checks++; if (revealed !== 64'h0 || flagged !== 64'h0) begin errors++; $display("FAIL newgame_maps got %h/%h exp 0/0", revealed, flagged); end
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL newgame_state got %b exp 01", game_state); end
  endtask

  task automatic test_flood;
    int cnt;
    start_board(64'h0, 256'h0);
    issue(2'b00, 6'd0);
    wait_idle(cnt);
    checks++; if (cnt !== 128) begin errors++; $display("FAIL flood_busy_cycles got %0d exp 128", cnt); end
    checks++; if (revealed !== {64{1'b1}}) begin errors++; $display("FAIL flood_revealed got %h exp all ones", revealed); end
    checks++; if (game_state !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL flood_win got %b/%b exp 10/0", game_state, busy); end
    issue(2'b01, 6'd3);
    checks++; if (flagged !== 64'h0 || game_state !== 2'b10) begin errors++; $display("FAIL win_drop got %h/%b exp 0/10", flagged, game_state); end
    issue(2'b10, 6'd0);
    checks++; if (revealed !== 64'h0 || game_state !== 2'b01) begin errors++; $display("FAIL win_newgame got %h/%b exp 0/01", revealed, game_state); end
  endtask

  task automatic test_column;
    int cnt;
    logic [63:0] m;
    m = 64'h0202020202020202;
    start_board(m, adj_of(m));
    issue(2'b00, 6'd7);
    wait_idle(cnt);
    checks++; if (cnt >= 2000) begin errors++; $display("FAIL column_timeout got %0d exp <2000", cnt); end
    checks++; if (revealed !== 64'hFCFCFCFCFCFCFCFC) begin errors++; $display("FAIL column_revealed got %h exp fcfcfcfcfcfcfcfc", revealed); end
    checks++; if (revealed[8] !== 1'b0) begin errors++; $display("FAIL column_nowrap got %b exp 0", revealed[8]); end
    checks++; if (game_state !== 2'b01) begin errors++; $display("FAIL column_state got %b exp 01", game_state); end
  endtask

  task automatic test_reset_mid_sweep;
    start_board(64'h0, 256'h0);
    issue(2'b00, 6'd0);
    repeat (29) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midsweep_busy got %b exp 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (revealed !== 64'h0 || game_state !== 2'b00) begin errors++; $display("FAIL abort_maps got %h/%b exp 0/00", revealed, game_state); end
    checks++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_outputs got %b/%b exp 0/0", busy, cmd_if.cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_flag;
    test_lose;
    test_flood;
    test_column;
    test_reset_mid_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
